// File: rtl/gobou_pkg.sv
// Shared types and arithmetic helpers for the gobou FC and conv engines.
package gobou_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      DRAIN,
      BIAS,
      WRITE,
      DONE
   } state_t;

   // Working width for the shared saturate/relu helpers; must cover ACCWIDTH.
   localparam int unsigned SAT_W = 64;

   function automatic int unsigned acc_width(input int unsigned dwidth,
                                             input int unsigned lwidth);
      return 2 * dwidth + lwidth;
   endfunction

   // Clamp x into the signed range of a w-bit value.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                        input int unsigned w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic signed [SAT_W-1:0] relu(input logic signed [SAT_W-1:0] x,
                                                    input logic en);
      return (en && (x < 0)) ? '0 : x;
   endfunction

endpackage

// File: rtl/gobou_fc_lane.sv
// One MAC lane: multiply register, accumulator, bias/rescale/saturate/ReLU finalise, result register.
module gobou_fc_lane
   import gobou_pkg::*;
#(
   parameter int unsigned DWIDTH    = 16,
   parameter int unsigned FRACWIDTH = 8,
   parameter int unsigned LWIDTH    = 10
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              clr,
   input  logic              rd_valid,
   input  logic              mul_valid,
   input  logic              fin_en,
   input  logic              bias_en,
   input  logic              relu_en,
   input  logic [DWIDTH-1:0] pixel,
   input  logic [DWIDTH-1:0] weight,
   output logic [DWIDTH-1:0] fin_c,
   output logic [DWIDTH-1:0] result
);

   localparam int unsigned ACCWIDTH = acc_width(DWIDTH, LWIDTH);
   localparam int unsigned MULWIDTH = 2 * DWIDTH;

   logic signed [MULWIDTH-1:0] mul;
   logic signed [ACCWIDTH-1:0] acc;
   logic signed [ACCWIDTH-1:0] bias_term;
   logic signed [ACCWIDTH-1:0] sum;
   logic signed [ACCWIDTH-1:0] shifted;
   logic signed [SAT_W-1:0]    clamped;

   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         mul    <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         if (rd_valid)
            mul <= MULWIDTH'($signed(pixel)) * MULWIDTH'($signed(weight));
         if (clr)
            acc <= '0;
         else if (mul_valid)
            acc <= acc + ACCWIDTH'(mul);
         if (fin_en)
            result <= fin_c;
      end
   end

   // During the second bias cycle the weight bus carries this lane's bias word.
   always_comb begin
      bias_term = '0;
      if (bias_en)
         bias_term = ACCWIDTH'($signed(weight)) <<< FRACWIDTH;
      sum     = acc + bias_term;
      shifted = sum >>> FRACWIDTH;
      clamped = relu(saturate(SAT_W'(shifted), DWIDTH), relu_en);
      fin_c   = DWIDTH'(clamped);
   end

endmodule

// File: rtl/gobou_fc_engine.sv
// Fully-connected layer engine: sequences CORE-wide neuron groups through MAC, bias, rescale and write-back.
module gobou_fc_engine
   import gobou_pkg::*;
#(
   parameter int unsigned DWIDTH    = 16,
   parameter int unsigned FRACWIDTH = 8,
   parameter int unsigned LWIDTH    = 10,
   parameter int unsigned CORE      = 16,
   parameter int unsigned IMGSIZE   = 12,
   parameter int unsigned NETSIZE   = 14
) (
   input  logic                   clk,
   input  logic                   xrst,
   input  logic                   req,
   input  logic [LWIDTH-1:0]      total_in,
   input  logic [LWIDTH-1:0]      total_out,
   input  logic [IMGSIZE-1:0]     input_addr,
   input  logic [IMGSIZE-1:0]     output_addr,
   input  logic [NETSIZE-1:0]     net_offset,
   input  logic                   bias_en,
   input  logic                   relu_en,
   input  logic [DWIDTH-1:0]      img_rdata,
   input  logic [CORE*DWIDTH-1:0] net_rdata,
   output logic [IMGSIZE-1:0]     img_addr,
   output logic                   img_we,
   output logic [DWIDTH-1:0]      img_wdata,
   output logic [NETSIZE-1:0]     net_addr,
   output logic                   busy,
   output logic                   ack
);

   state_t               state;
   logic [LWIDTH-1:0]    tin;
   logic [LWIDTH-1:0]    tout;
   logic [LWIDTH-1:0]    cnt;
   logic [LWIDTH-1:0]    nbase;
   logic [IMGSIZE-1:0]   in_base;
   logic [IMGSIZE-1:0]   out_base;
   logic [NETSIZE-1:0]   row;
   logic                 be_q;
   logic                 re_q;
   logic                 ph;
   logic                 rd_valid;
   logic                 mul_valid;

   logic [LWIDTH-1:0]    rem_c;
   logic [LWIDTH-1:0]    nv_c;
   logic                 last_c;
   logic                 clr_c;
   logic                 fin_en_c;
   logic [LWIDTH-1:0]    sel_c;
   logic [NETSIZE-1:0]   row_next_c;
   logic [DWIDTH-1:0]    wr_next_c;
   logic [DWIDTH-1:0]    fin_c  [CORE];
   logic [DWIDTH-1:0]    result [CORE];

   // Group geometry and write-data selection.
   always_comb begin
      rem_c      = tout - nbase;
      last_c     = rem_c <= LWIDTH'(CORE);
      nv_c       = last_c ? rem_c : LWIDTH'(CORE);
      clr_c      = state inside {IDLE, WRITE, DONE};
      fin_en_c   = (state == BIAS) && ph;
      row_next_c = row + NETSIZE'(tin) + NETSIZE'(1);
      sel_c      = (state == BIAS) ? '0 : cnt + LWIDTH'(1);
      wr_next_c  = '0;
      for (int k = 0; k < CORE; k++) begin
         if (LWIDTH'(k) == sel_c)
            wr_next_c = (state == BIAS) ? fin_c[k] : result[k];
      end
   end

   for (genvar k = 0; k < CORE; k++) begin : g_lane
      gobou_fc_lane #(
         .DWIDTH   (DWIDTH),
         .FRACWIDTH(FRACWIDTH),
         .LWIDTH   (LWIDTH)
      ) u_lane (
         .clk      (clk),
         .xrst     (xrst),
         .clr      (clr_c),
         .rd_valid (rd_valid),
         .mul_valid(mul_valid),
         .fin_en   (fin_en_c),
         .bias_en  (be_q),
         .relu_en  (re_q),
         .pixel    (img_rdata),
         .weight   (net_rdata[k*DWIDTH +: DWIDTH]),
         .fin_c    (fin_c[k]),
         .result   (result[k])
      );
   end

   // Controller: addresses and strobes are issued one cycle ahead of the state they belong to.
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         state     <= IDLE;
         tin       <= '0;
         tout      <= '0;
         cnt       <= '0;
         nbase     <= '0;
         in_base   <= '0;
         out_base  <= '0;
         row       <= '0;
         be_q      <= 1'b0;
         re_q      <= 1'b0;
         ph        <= 1'b0;
         rd_valid  <= 1'b0;
         mul_valid <= 1'b0;
         img_addr  <= '0;
         img_we    <= 1'b0;
         img_wdata <= '0;
         net_addr  <= '0;
         busy      <= 1'b0;
         ack       <= 1'b0;
      end else begin
         ack       <= 1'b0;
         img_we    <= 1'b0;
         rd_valid  <= (state == MAC);
         mul_valid <= rd_valid;
         case (state)
            IDLE: begin
               if (req) begin
                  tin      <= total_in;
                  tout     <= total_out;
                  in_base  <= input_addr;
                  out_base <= output_addr;
                  row      <= net_offset;
                  be_q     <= bias_en;
                  re_q     <= relu_en;
                  cnt      <= '0;
                  nbase    <= '0;
                  ph       <= 1'b0;
                  busy     <= 1'b1;
                  net_addr <= net_offset;
                  img_addr <= input_addr;
                  if (total_out == '0) begin
                     state <= DONE;
                     ack   <= 1'b1;
                  end else if (total_in == '0) begin
                     state <= BIAS;
                  end else begin
                     state <= MAC;
                  end
               end
            end
            MAC: begin
               if (cnt == tin - LWIDTH'(1)) begin
                  state <= DRAIN;
                  ph    <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt      <= cnt + LWIDTH'(1);
                  img_addr <= in_base + IMGSIZE'(cnt) + IMGSIZE'(1);
                  net_addr <= row + NETSIZE'(cnt) + NETSIZE'(1);
               end
            end
            DRAIN: begin
               ph <= ~ph;
               if (ph) begin
                  state    <= BIAS;
                  net_addr <= row + NETSIZE'(tin);
               end
            end
            BIAS: begin
               ph <= ~ph;
               if (ph) begin
                  state     <= WRITE;
                  cnt       <= '0;
                  img_we    <= 1'b1;
                  img_addr  <= out_base + IMGSIZE'(nbase);
                  img_wdata <= wr_next_c;
               end
            end
            WRITE: begin
               if (cnt == nv_c - LWIDTH'(1)) begin
                  cnt <= '0;
                  ph  <= 1'b0;
                  if (last_c) begin
                     state <= DONE;
                     ack   <= 1'b1;
                  end else begin
                     nbase    <= nbase + LWIDTH'(CORE);
                     row      <= row_next_c;
                     img_addr <= in_base;
                     if (tin == '0) begin
                        state    <= BIAS;
                        net_addr <= row_next_c;
                     end else begin
                        state    <= MAC;
                        net_addr <= row_next_c;
                     end
                  end
               end else begin
                  cnt       <= cnt + LWIDTH'(1);
                  img_we    <= 1'b1;
                  img_addr  <= img_addr + IMGSIZE'(1);
                  img_wdata <= wr_next_c;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gobou_fc_engine.sv
// Self-checking bench for gobou_fc_engine (CORE=4): directed table, reference-model random jobs, reset/req corners.
module tb_gobou_fc_engine;

   localparam int DW      = 16;
   localparam int LW      = 10;
   localparam int CORE    = 4;
   localparam int IMGSIZE = 12;
   localparam int NETSIZE = 14;
   localparam int IN_BASE = 100;
   localparam int NET_OFF = 200;

   logic                 clk = 1'b0;
   logic                 xrst = 1'b1;
   logic                 req = 1'b0;
   logic [LW-1:0]        total_in = '0;
   logic [LW-1:0]        total_out = '0;
   logic [IMGSIZE-1:0]   input_addr = '0;
   logic [IMGSIZE-1:0]   output_addr = '0;
   logic [NETSIZE-1:0]   net_offset = '0;
   logic                 bias_en = 1'b0;
   logic                 relu_en = 1'b0;
   logic [DW-1:0]        img_rdata;
   logic [CORE*DW-1:0]   net_rdata;
   logic [IMGSIZE-1:0]   img_addr;
   logic                 img_we;
   logic [DW-1:0]        img_wdata;
   logic [NETSIZE-1:0]   net_addr;
   logic                 busy;
   logic                 ack;

   logic [DW-1:0]        img_mem [0:4095];
   logic [CORE*DW-1:0]   net_mem [0:16383];

   gobou_fc_engine #(
      .DWIDTH(DW), .FRACWIDTH(8), .LWIDTH(LW), .CORE(CORE), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE)
   ) dut (
      .clk(clk), .xrst(xrst), .req(req), .total_in(total_in), .total_out(total_out),
      .input_addr(input_addr), .output_addr(output_addr), .net_offset(net_offset),
      .bias_en(bias_en), .relu_en(relu_en), .img_rdata(img_rdata), .net_rdata(net_rdata),
      .img_addr(img_addr), .img_we(img_we), .img_wdata(img_wdata), .net_addr(net_addr),
      .busy(busy), .ack(ack)
   );

   always #5 clk = ~clk;

   // Synchronous memories with one cycle of read latency.
   always @(posedge clk) begin
      img_rdata <= img_mem[img_addr];
      net_rdata <= net_mem[net_addr];
   end

   typedef struct {
      int addr;
      int data;
   } wr_t;

   typedef struct {
      string name;
      int    tin;
      int    tout;
      int    oaddr;
      bit    be;
      bit    re;
      int    pmode;
      int    wval;
      int    bval;
      int    exp_val;
      int    exp_n;
      int    exp_lat;
   } vec_t;

   wr_t exp_q[$];
   wr_t got_q[$];
   int  exp_lat;
   int  ack_at;
   int  vecs = 0;
   int  errs = 0;

   task automatic check(input string name, input longint got, input longint exp);
      vecs++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int lane_w(input int row, input int k);
      logic [CORE*DW-1:0] word;
      logic [DW-1:0]      h;
      word = net_mem[row % 16384];
      h    = word[k*DW +: DW];
      return int'($signed(h));
   endfunction

   function automatic int pix(input int i);
      return int'($signed(img_mem[(IN_BASE + i) % 4096]));
   endfunction

   // Reference: each neuron is a plain dot product plus bias, floored, clamped, optionally rectified.
   task automatic build_model(input int tin, input int tout, input int oaddr, input bit be, input bit re);
      exp_q.delete();
      exp_lat = 0;
      for (int n = 0; n < tout; n++) begin
         int     g, k, rb;
         longint acc;
         wr_t    w;
         g   = n / CORE;
         k   = n % CORE;
         rb  = NET_OFF + g * (tin + 1);
         acc = 0;
         for (int i = 0; i < tin; i++)
            acc += longint'(pix(i)) * longint'(lane_w(rb + i, k));
         if (be) acc += longint'(lane_w(rb + tin, k)) * 256;
         acc = acc >>> 8;
         if (acc > 32767) acc = 32767;
         if (acc < -32768) acc = -32768;
         if (re && acc < 0) acc = 0;
         w.addr = (oaddr + n) % 4096;
         w.data = int'(acc);
         exp_q.push_back(w);
      end
      for (int g = 0; g * CORE < tout; g++) begin
         int nv;
         nv = (tout - g * CORE < CORE) ? tout - g * CORE : CORE;
         exp_lat += (tin > 0) ? tin + 4 + nv : nv + 2;
      end
   endtask

   task automatic fill_const(input int tin, input int tout, input int pmode, input int wval, input int bval);
      for (int i = 0; i < tin; i++)
         img_mem[IN_BASE + i] = (pmode == 0) ? DW'(256 * (i + 1)) : DW'(32767);
      for (int g = 0; g * CORE < tout; g++) begin
         for (int i = 0; i < tin; i++)
            net_mem[NET_OFF + g * (tin + 1) + i] = {CORE{DW'(wval)}};
         net_mem[NET_OFF + g * (tin + 1) + tin] = {CORE{DW'(bval)}};
      end
   endtask

   function automatic logic [DW-1:0] rnd_word(input bit big);
      if (big) return DW'($urandom_range(0, 65535));
      return DW'(int'($urandom_range(0, 600)) - 300);
   endfunction

   task automatic fill_random(input int tin, input int tout, input bit big);
      for (int i = 0; i < tin; i++)
         img_mem[IN_BASE + i] = rnd_word(big);
      for (int g = 0; g * CORE < tout; g++)
         for (int i = 0; i <= tin; i++)
            for (int k = 0; k < CORE; k++)
               net_mem[NET_OFF + g * (tin + 1) + i][k*DW +: DW] = rnd_word(big);
   endtask

   // Runs one job, captures writes and ack timing, and compares against the reference model.
   task automatic run_job(input string name, input int tin, input int tout, input int oaddr,
                          input bit be, input bit re, input bit poke);
      build_model(tin, tout, oaddr, be, re);
      got_q.delete();
      @(negedge clk);
      total_in    = LW'(tin);
      total_out   = LW'(tout);
      input_addr  = IMGSIZE'(IN_BASE);
      output_addr = IMGSIZE'(oaddr);
      net_offset  = NETSIZE'(NET_OFF);
      bias_en     = be;
      relu_en     = re;
      req         = 1'b1;
      @(posedge clk);
      #1;
      req    = 1'b0;
      ack_at = -1;
      for (int c = 0; c < 2000; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (poke && c == 3) begin
            req         = 1'b1;
            total_in    = LW'(tin + 3);
            output_addr = IMGSIZE'(oaddr + 50);
         end
         if (poke && c == 4) begin
            req         = 1'b0;
            total_in    = LW'(tin);
            output_addr = IMGSIZE'(oaddr);
         end
         if (img_we) got_q.push_back('{addr: int'(img_addr), data: int'($signed(img_wdata))});
         if (ack) begin
            ack_at = c;
            check({name, " busy_at_ack"}, longint'(busy), 1);
            break;
         end
      end
      check({name, " ack_cycles"}, ack_at, exp_lat);
      @(posedge clk);
      #1;
      check({name, " ack_pulse"}, longint'(ack), 0);
      check({name, " busy_after"}, longint'(busy), 0);
      check({name, " nwrites"}, got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         check($sformatf("%s addr[%0d]", name, j), got_q[j].addr, exp_q[j].addr);
         check($sformatf("%s data[%0d]", name, j), got_q[j].data, exp_q[j].data);
      end
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{"basic",     4, 3, 1000, 1'b0, 1'b0, 0,    256,    0,   2560, 3, 11};
      tbl[1] = '{"sat_pos",   4, 4, 1100, 1'b0, 1'b0, 1,  32767,    0,  32767, 4, 12};
      tbl[2] = '{"sat_neg",   4, 4, 1100, 1'b0, 1'b0, 1, -32767,    0, -32768, 4, 12};
      tbl[3] = '{"sat_relu",  4, 4, 1100, 1'b0, 1'b1, 1, -32767,    0,      0, 4, 12};
      tbl[4] = '{"partial",   4, 6, 1200, 1'b1, 1'b0, 0,    256,  512,   3072, 6, 22};
      tbl[5] = '{"bias_only", 0, 3, 1300, 1'b1, 1'b0, 0,    256,   -3,     -3, 3, 5};
      tbl[6] = '{"bias_relu", 0, 3, 1300, 1'b1, 1'b1, 0,    256,   -3,      0, 3, 5};
      tbl[7] = '{"zero_out",  4, 0, 1400, 1'b0, 1'b0, 0,    256,    0,      0, 0, 0};
      tbl[8] = '{"wrap",      2, 5, 4094, 1'b0, 1'b0, 0,    256,    0,    768, 5, 17};

      repeat (2) @(posedge clk);
      #1;
      check("reset img_we", longint'(img_we), 0);
      check("reset ack", longint'(ack), 0);
      check("reset busy", longint'(busy), 0);
      check("reset img_addr", longint'(img_addr), 0);
      check("reset net_addr", longint'(net_addr), 0);
      check("reset img_wdata", longint'(img_wdata), 0);
      @(negedge clk);
      xrst = 1'b0;

      // Directed table: fixed expectations plus the model comparison inside run_job.
      foreach (tbl[v]) begin
         fill_const(tbl[v].tin, tbl[v].tout, tbl[v].pmode, tbl[v].wval, tbl[v].bval);
         run_job(tbl[v].name, tbl[v].tin, tbl[v].tout, tbl[v].oaddr, tbl[v].be, tbl[v].re, 1'b0);
         check({tbl[v].name, " tbl_nwrites"}, got_q.size(), tbl[v].exp_n);
         check({tbl[v].name, " tbl_lat"}, ack_at, tbl[v].exp_lat);
         foreach (got_q[j]) begin
            check($sformatf("%s tbl_addr[%0d]", tbl[v].name, j), got_q[j].addr,
                  (tbl[v].oaddr + j) % 4096);
            check($sformatf("%s tbl_data[%0d]", tbl[v].name, j), got_q[j].data, tbl[v].exp_val);
         end
      end

      // Reset during the second write aborts the job immediately.
      begin
         int nwe;
         bit seen;
         nwe  = 0;
         seen = 1'b0;
         fill_const(4, 3, 0, 256, 0);
         @(negedge clk);
         total_in = LW'(4); total_out = LW'(3); input_addr = IMGSIZE'(IN_BASE);
         output_addr = IMGSIZE'(1500); net_offset = NETSIZE'(NET_OFF);
         bias_en = 1'b0; relu_en = 1'b0; req = 1'b1;
         @(posedge clk);
         #1;
         req = 1'b0;
         for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (img_we) nwe++;
            if (nwe == 2) seen = 1'b1;
         end
         check("rst_mid reached_2nd_write", longint'(seen), 1);
         xrst = 1'b1;
         #1;
         check("rst_mid img_we", longint'(img_we), 0);
         check("rst_mid busy", longint'(busy), 0);
         nwe = 0;
         repeat (4) begin
            @(posedge clk);
            #1;
            nwe += int'(img_we) + int'(ack);
         end
         check("rst_mid quiet", nwe, 0);
         @(negedge clk);
         xrst = 1'b0;
         run_job("after_rst", 4, 3, 1000, 1'b0, 1'b0, 1'b0);
      end

      // req while busy with different parameters must change nothing.
      begin
         int extra;
         extra = 0;
         fill_const(4, 3, 0, 256, 0);
         run_job("req_busy", 4, 3, 1600, 1'b0, 1'b0, 1'b1);
         repeat (20) begin
            @(posedge clk);
            #1;
            extra += int'(ack) + int'(img_we);
         end
         check("req_busy no_extra", extra, 0);
      end

      // Randomized jobs against the reference model.
      for (int r = 0; r < 14; r++) begin
         int tin, tout, oaddr;
         bit be, re, big;
         tin   = $urandom_range(0, 6);
         tout  = $urandom_range(1, 9);
         oaddr = $urandom_range(500, 4095);
         be    = 1'($urandom_range(0, 1));
         re    = 1'($urandom_range(0, 1));
         big   = ($urandom_range(0, 3) == 0);
         fill_random(tin, tout, big);
         run_job($sformatf("rand%0d", r), tin, tout, oaddr, be, re, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
